fbcpu_param_core: RTL and testbench

//  Parametrised successor of the FB accumulator CPU: fetch/decode/execute core with one accumulator (ACC).

---
 rtl/fbcpu_param_core.sv | 209 ++++++++++++++++++++
 tb/tb_fbcpu_param_core.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fbcpu_param_core.sv
// fbcpu_param_core: fetch/decode/execute accumulator CPU with a req/ready memory bus.
// One accumulator (acc), a carry flag and a sticky fault flag. Memory accesses hold
// their request until mem_ready, so wait-state RAM is supported.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   mem_req    memory access request
//   mem_we     write enable, qualified by mem_req
//   mem_addr   access address
//   mem_wdata  store data
//   mem_rdata  read data, valid when mem_ready=1
//   mem_ready  access completes this cycle
//   pc         program counter
//   acc        accumulator
//   carry      carry/borrow of last ADD/SUB
//   halted     core stopped by HALT or fault
//   fault      sticky: divide-by-zero or illegal opcode
module fbcpu_param_core #(
   parameter int unsigned ADDRESS_WIDTH = 6,
   parameter int unsigned DATA_WIDTH    = 10,  // must equal OPC_WIDTH + ADDRESS_WIDTH
   parameter int unsigned OPC_WIDTH     = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   input  logic [DATA_WIDTH-1:0]    mem_rdata,
   input  logic                     mem_ready,
   output logic [ADDRESS_WIDTH-1:0] pc,
   output logic [DATA_WIDTH-1:0]    acc,
   output logic                     carry,
   output logic                     halted,
   output logic                     fault
);

   localparam logic [OPC_WIDTH-1:0] OpLoad  = OPC_WIDTH'(0);
   localparam logic [OPC_WIDTH-1:0] OpStore = OPC_WIDTH'(1);
   localparam logic [OPC_WIDTH-1:0] OpAdd   = OPC_WIDTH'(2);
   localparam logic [OPC_WIDTH-1:0] OpSub   = OPC_WIDTH'(3);
   localparam logic [OPC_WIDTH-1:0] OpMul   = OPC_WIDTH'(4);
   localparam logic [OPC_WIDTH-1:0] OpDiv   = OPC_WIDTH'(5);
   localparam logic [OPC_WIDTH-1:0] OpJmp   = OPC_WIDTH'(6);
   localparam logic [OPC_WIDTH-1:0] OpJz    = OPC_WIDTH'(7);
   localparam logic [OPC_WIDTH-1:0] OpNop   = OPC_WIDTH'(8);
   localparam logic [OPC_WIDTH-1:0] OpHalt  = OPC_WIDTH'(9);
   localparam logic [OPC_WIDTH-1:0] OpAnd   = OPC_WIDTH'(10);
   localparam logic [OPC_WIDTH-1:0] OpOr    = OPC_WIDTH'(11);
   localparam logic [OPC_WIDTH-1:0] OpLdi   = OPC_WIDTH'(12);
   localparam logic [OPC_WIDTH-1:0] OpJnz   = OPC_WIDTH'(13);

   typedef enum logic [1:0] {StFetch, StDecode, StMem, StHalt} state_e;

   state_e                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
   logic [DATA_WIDTH-1:0]    ir_q, ir_d;
   logic [DATA_WIDTH-1:0]    acc_q, acc_d;
   logic                     carry_q, carry_d;
   logic                     fault_q, fault_d;

   logic [OPC_WIDTH-1:0]     opcode;
   logic [ADDRESS_WIDTH-1:0] operand;
   logic [DATA_WIDTH:0]      sum;
   logic [DATA_WIDTH:0]      diff;
   logic [DATA_WIDTH-1:0]    prod;
   logic [DATA_WIDTH-1:0]    quot;
   logic                     div_zero;

   // Internal bus drive, before reset gating.
   logic                     req_int;
   logic                     we_int;
   logic [ADDRESS_WIDTH-1:0] addr_int;
   logic [DATA_WIDTH-1:0]    wdata_int;

   assign opcode  = ir_q[DATA_WIDTH-1 -: OPC_WIDTH];
   assign operand = ir_q[ADDRESS_WIDTH-1:0];

   // Extra MSB of sum is the carry; extra MSB of diff is the borrow (acc < rdata).
   assign sum      = {1'b0, acc_q} + {1'b0, mem_rdata};
   assign diff     = {1'b0, acc_q} - {1'b0, mem_rdata};
   assign prod     = acc_q * mem_rdata;  // context width keeps only the low DATA_WIDTH bits
   assign div_zero = (mem_rdata == '0);
   assign quot     = div_zero ? acc_q : acc_q / mem_rdata;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StFetch;
         pc_q    <= '0;
         ir_q    <= '0;
         acc_q   <= '0;
         carry_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         acc_q   <= acc_d;
         carry_q <= carry_d;
         fault_q <= fault_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      acc_d     = acc_q;
      carry_d   = carry_q;
      fault_d   = fault_q;
      req_int   = 1'b0;
      we_int    = 1'b0;
      addr_int  = '0;
      wdata_int = '0;

      unique case (state_q)
         StFetch: begin
            req_int  = 1'b1;
            addr_int = pc_q;
            if (mem_ready) begin
               ir_d    = mem_rdata;
               pc_d    = pc_q + ADDRESS_WIDTH'(1);
               state_d = StDecode;
            end
         end

         StDecode: begin
            case (opcode)
               OpLoad, OpStore, OpAdd, OpSub, OpMul, OpDiv, OpAnd, OpOr: state_d = StMem;
               OpJmp: begin
                  pc_d    = operand;
                  state_d = StFetch;
               end
               OpJz: begin
                  if (acc_q == '0) pc_d = operand;
                  state_d = StFetch;
               end
               OpJnz: begin
                  if (acc_q != '0) pc_d = operand;
                  state_d = StFetch;
               end
               OpNop:  state_d = StFetch;
               OpLdi: begin
                  acc_d   = DATA_WIDTH'(operand);
                  state_d = StFetch;
               end
               OpHalt: state_d = StHalt;
               default: begin
                  fault_d = 1'b1;
                  state_d = StHalt;
               end
            endcase
         end

         StMem: begin
            req_int  = 1'b1;
            addr_int = operand;
            if (opcode == OpStore) begin
               we_int    = 1'b1;
               wdata_int = acc_q;
            end
            if (mem_ready) begin
               state_d = StFetch;
               case (opcode)
                  OpLoad: acc_d = mem_rdata;
                  OpAdd: begin
                     acc_d   = sum[DATA_WIDTH-1:0];
                     carry_d = sum[DATA_WIDTH];
                  end
                  OpSub: begin
                     acc_d   = diff[DATA_WIDTH-1:0];
                     carry_d = diff[DATA_WIDTH];
                  end
                  OpMul: acc_d = prod;
                  OpDiv: begin
                     if (div_zero) begin
                        fault_d = 1'b1;
                        state_d = StHalt;
                     end else begin
                        acc_d = quot;
                     end
                  end
                  OpAnd: acc_d = acc_q & mem_rdata;
                  OpOr:  acc_d = acc_q | mem_rdata;
                  default: ;  // STORE: the write completes on this handshake
               endcase
            end
         end

         StHalt: ;

         default: state_d = StFetch;
      endcase
   end

   // Bus is forced quiet while reset is held so an in-flight access drops immediately.
   assign mem_req   = rst & req_int;
   assign mem_we    = rst & we_int;
   assign mem_addr  = rst ? addr_int : '0;
   assign mem_wdata = rst ? wdata_int : '0;

   assign pc     = pc_q;
   assign acc    = acc_q;
   assign carry  = carry_q;
   assign halted = (state_q == StHalt);
   assign fault  = fault_q;

endmodule

// File: tb/tb_fbcpu_param_core.sv
// Testbench for fbcpu_param_core: an instruction-level reference model predicts every bus
// transaction and the final architectural state; a bus process acts as the RAM, inserts
// wait states and checks each completed transaction against the expected queue.
module tb_fbcpu_param_core;

   localparam int AW = 6;
   localparam int DW = 10;
   localparam int OW = 4;

   typedef struct {
      logic [AW-1:0] addr;
      logic          we;
      logic [DW-1:0] wdata;
   } txn_t;

   logic          clk;
   logic          rst;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ready;
   logic [AW-1:0] pc;
   logic [DW-1:0] acc;
   logic          carry;
   logic          halted;
   logic          fault;

   fbcpu_param_core #(
      .ADDRESS_WIDTH(AW),
      .DATA_WIDTH   (DW),
      .OPC_WIDTH    (OW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .mem_req  (mem_req),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .mem_ready(mem_ready),
      .pc       (pc),
      .acc      (acc),
      .carry    (carry),
      .halted   (halted),
      .fault    (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int            total = 0;
   int            bad   = 0;
   logic [DW-1:0] ram  [0:63];
   logic [DW-1:0] mram [0:63];
   txn_t          exp_q[$];
   int            mode      = 0;  // 0 no waits, 1 random, 3 directed, 4 stall the STORE forever
   int            txn_idx   = 0;
   int            stalls    = 0;
   int            n_writes  = 0;
   int            last_cyc  = 0;
   int            exp_acc, exp_carry, exp_pc, exp_fault, exp_cyc;

   task automatic chk(input string name, input int act, input int expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   function automatic logic [DW-1:0] ins(input int op, input int opd);
      return DW'((op << 6) | opd);
   endfunction

   // Instruction-at-a-time interpreter; pushes every expected bus transaction.
   task automatic model(output bit ok);
      int  p, a, c, f, cyc, op, opd, d, s;
      bit  done;
      p = 0; a = 0; c = 0; f = 0; cyc = 0; ok = 0; done = 0;
      for (int step = 0; step < 100 && !done; step++) begin
         exp_q.push_back('{addr: AW'(p), we: 1'b0, wdata: '0});
         op  = int'(mram[p]) / 64;
         opd = int'(mram[p]) % 64;
         p   = (p + 1) % 64;
         cyc += 2;
         if (op <= 5 || op == 10 || op == 11) begin
            cyc++;
            exp_q.push_back('{addr: AW'(opd), we: (op == 1), wdata: (op == 1) ? DW'(a) : '0});
            d = int'(mram[opd]);
            case (op)
               0: a = d;
               1: mram[opd] = DW'(a);
               2: begin s = a + d; c = (s >= 1024) ? 1 : 0; a = s % 1024; end
               3: begin c = (a < d) ? 1 : 0; a = (a - d + 1024) % 1024; end
               4: a = (a * d) % 1024;
               5: if (d == 0) begin f = 1; done = 1; end else a = a / d;
               10: a = a & d;
               11: a = a | d;
               default: ;
            endcase
         end else begin
            case (op)
               6:  p = opd;
               7:  if (a == 0) p = opd;
               13: if (a != 0) p = opd;
               12: a = opd;
               9:  done = 1;
               14, 15: begin f = 1; done = 1; end
               default: ;
            endcase
         end
      end
      ok        = done;
      exp_acc   = a;
      exp_carry = c;
      exp_pc    = p;
      exp_fault = f;
      exp_cyc   = cyc;
   endtask

   function automatic int pick_stall();
      case (mode)
         1: return int'($urandom_range(0, 2));
         3: return (txn_idx == 0 || txn_idx == 5) ? 3 : 0;
         4: return (txn_idx == 5) ? 1000000 : 0;
         default: return 0;
      endcase
   endfunction

   // RAM responder and transaction monitor.
   initial begin
      bit in_txn;
      int stall_left;
      int held;
      txn_t e;
      in_txn = 0;
      stall_left = 0;
      held = 0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (!rst || !mem_req) begin
            in_txn    = 0;
            mem_ready = 1'($urandom_range(0, 1));  // must be ignored without a request
            mem_rdata = DW'($urandom);
         end else begin
            if (in_txn) begin
               chk("bus_hold", int'({mem_addr, mem_we, mem_wdata}), held);
            end else begin
               in_txn     = 1;
               stall_left = pick_stall();
               held       = int'({mem_addr, mem_we, mem_wdata});
            end
            if (stall_left > 0) begin
               stall_left--;
               stalls++;
               mem_ready = 1'b0;
               mem_rdata = DW'($urandom);
            end else begin
               mem_ready = 1'b1;
               mem_rdata = ram[mem_addr];
               if (exp_q.size() == 0) begin
                  chk("unexpected_txn", int'(mem_addr), -1);
               end else begin
                  e = exp_q.pop_front();
                  chk("txn_addr", int'(mem_addr), int'(e.addr));
                  chk("txn_we", int'(mem_we), int'(e.we));
                  if (e.we) chk("txn_wdata", int'(mem_wdata), int'(e.wdata));
               end
               if (mem_we) begin
                  ram[mem_addr] = mem_wdata;
                  n_writes++;
               end
               txn_idx++;
               in_txn = 0;
            end
         end
      end
   end

   task automatic clr();
      for (int i = 0; i < 64; i++) ram[i] = '0;
   endtask

   task automatic run_prog(input string tag, input int wmode);
      bit ok;
      int cyc;
      int diffs;
      for (int i = 0; i < 64; i++) mram[i] = ram[i];
      exp_q.delete();
      model(ok);
      rst      = 1'b0;
      mode     = wmode;
      txn_idx  = 0;
      stalls   = 0;
      n_writes = 0;
      @(posedge clk);
      #1;
      chk({tag, "_rst_req"}, int'(mem_req), 0);
      chk({tag, "_rst_pc"}, int'(pc), 0);
      chk({tag, "_rst_acc"}, int'({acc, carry, fault, halted}), 0);
      @(posedge clk);
      #2 rst = 1'b1;
      cyc = 0;
      while (!halted && cyc < 3000) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      last_cyc = cyc;
      chk({tag, "_halted"}, int'(halted), 1);
      chk({tag, "_cycles"}, cyc, exp_cyc + stalls);
      chk({tag, "_acc"}, int'(acc), exp_acc);
      chk({tag, "_carry"}, int'(carry), exp_carry);
      chk({tag, "_pc"}, int'(pc), exp_pc);
      chk({tag, "_fault"}, int'(fault), exp_fault);
      chk({tag, "_pending"}, exp_q.size(), 0);
      diffs = 0;
      for (int i = 0; i < 64; i++) if (ram[i] !== mram[i]) diffs++;
      chk({tag, "_ram_image"}, diffs, 0);
   endtask

   task automatic load_t1();
      clr();
      ram[0]  = ins(0, 20);
      ram[1]  = ins(2, 21);
      ram[2]  = ins(1, 22);
      ram[3]  = ins(9, 0);
      ram[20] = 10'd5;
      ram[21] = 10'd7;
   endtask

   initial begin
      bit ok;
      int cnt;
      rst = 1'b0;

      // Basic LOAD/ADD/STORE/HALT.
      load_t1();
      run_prog("t1", 0);
      chk("t1_ram22", int'(ram[22]), 12);
      chk("t1_cyc11", last_cyc, 11);
      chk("t1_pc4", int'(pc), 4);

      // ADD carry out and SUB borrow.
      clr();
      ram[0] = ins(0, 20); ram[1] = ins(2, 21); ram[2] = ins(9, 0);
      ram[20] = 10'd1000; ram[21] = 10'd30;
      run_prog("add", 0);
      chk("add_acc6", int'(acc), 6);
      chk("add_c1", int'(carry), 1);
      clr();
      ram[0] = ins(12, 5); ram[1] = ins(3, 20); ram[2] = ins(9, 0);
      ram[20] = 10'd7;
      run_prog("sub", 0);
      chk("sub_acc1022", int'(acc), 1022);
      chk("sub_c1", int'(carry), 1);

      // Countdown loop with JNZ.
      clr();
      ram[0] = ins(12, 3); ram[1] = ins(3, 10); ram[2] = ins(13, 1); ram[3] = ins(9, 0);
      ram[10] = 10'd1;
      run_prog("loop", 0);
      chk("loop_acc0", int'(acc), 0);
      chk("loop_cyc", last_cyc, 19);

      // JZ taken from acc=0.
      clr();
      ram[0] = ins(7, 5); ram[1] = ins(9, 0); ram[5] = ins(12, 9); ram[6] = ins(9, 0);
      run_prog("jz", 0);
      chk("jz_acc9", int'(acc), 9);
      chk("jz_pc7", int'(pc), 7);

      // PC wraps 63 -> 0; JNZ not taken then taken.
      clr();
      ram[0] = ins(13, 2); ram[1] = ins(6, 63); ram[2] = ins(9, 0); ram[63] = ins(12, 7);
      run_prog("wrap", 0);
      chk("wrap_acc7", int'(acc), 7);
      chk("wrap_pc3", int'(pc), 3);

      // Wait states in FETCH and STORE.
      load_t1();
      run_prog("wait", 3);
      chk("wait_cyc17", last_cyc, 17);
      chk("wait_one_write", n_writes, 1);
      chk("wait_ram22", int'(ram[22]), 12);

      // Divide by zero and illegal opcode.
      clr();
      ram[0] = ins(12, 9); ram[1] = ins(5, 30); ram[2] = ins(12, 1);
      run_prog("div0", 0);
      chk("div0_fault", int'({fault, halted}), 3);
      chk("div0_acc9", int'(acc), 9);
      clr();
      ram[0] = ins(12, 4); ram[1] = ins(15, 0);
      run_prog("ill", 0);
      chk("ill_fault", int'({fault, halted}), 3);
      chk("ill_acc4", int'(acc), 4);

      // Reset during a stalled STORE.
      load_t1();
      for (int i = 0; i < 64; i++) mram[i] = ram[i];
      exp_q.delete();
      model(ok);
      rst = 1'b0; mode = 4; txn_idx = 0; n_writes = 0;
      @(posedge clk);
      #2 rst = 1'b1;
      cnt = 0;
      while (!(mem_req && mem_we) && cnt < 100) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      chk("rst_store_reached", int'(mem_req && mem_we), 1);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      exp_q.delete();
      chk("rst_req_drop", int'({mem_req, mem_we}), 0);
      chk("rst_bus_zero", int'({mem_addr, mem_wdata}), 0);
      chk("rst_regs_zero", int'({pc, acc, carry, halted, fault}), 0);
      chk("rst_no_write", n_writes, 0);
      chk("rst_ram22", int'(ram[22]), 0);
      run_prog("rst_restart", 0);
      chk("rst_restart_ram22", int'(ram[22]), 12);

      // Random programs with random wait states.
      for (int n = 0; n < 25; n++) begin
         do begin
            for (int i = 0; i < 64; i++) ram[i] = DW'($urandom_range(0, 1023));
            for (int i = 0; i < 64; i++) mram[i] = ram[i];
            exp_q.delete();
            model(ok);
         end while (!ok);
         run_prog("rnd", 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
